sweep_ctrl: RTL
===============

# sweep_ctrl

Sequencer for the 8-bit up/down counter. It drives the counter's `enable` and `direction` inputs to produce a programmed triangle sweep. First it seeks the counter to a low bound. It then counts up to a high bound and back down, and repeats for a requested number of periods. It sits beside the counter, reads the counter's registered output, and reports `busy`/`done`/`err` to the surrounding control logic.

## Interface
- `WIDTH`, 8, counter value width; must match the counter.
- `CYC_W`, 8, width of period-count field.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle request; sampled only in IDLE.
- `stop` input 1: abort; sampled in any active state.
- `lo` input WIDTH: sweep low bound; captured on accepted `start`.
- `hi` input WIDTH: sweep high bound; captured on accepted `start`.
- `n_cycles` input CYC_W: number of full up-down periods; captured on accepted `start`.
- `counter_value` input WIDTH: the counter's registered output.
- `enable` output 1: counter enable.
- `direction` output 1: counter direction, 1 = up, 0 = down.
- `busy` output 1: high in any non-IDLE state.
- `done` output 1: one-cycle pulse on normal completion.
- `err` output 1: one-cycle pulse on a rejected `start`.

## Operation
- States: IDLE, SEEK, UP, DOWN, plus DWELL under the macro.
- `enable` and `direction` are combinational from the state, `counter_value` and captured config. This lets turnarounds cost no idle cycle.
- IDLE: `enable`=0, `direction`=1.
  - `start` with `lo < hi` and `n_cycles != 0`: capture config, clear the period counter, go to SEEK.
  - Otherwise `err` pulses the next cycle and the block stays in IDLE.
- SEEK:
  - `counter_value < lo`: enable=1, dir=1.
  - `counter_value > lo`: enable=1, dir=0.
  - `counter_value == lo`: enable=1, dir=1, go to UP.
- UP:
  - While `counter_value != hi`: enable=1, dir=1.
  - At `== hi`: enable=1, dir=0, go to DOWN.
- DOWN:
  - While `counter_value != lo`: enable=1, dir=0.
  - At `== lo`, the period count increments.
  - If it now equals `n_cycles`: enable=0, go to IDLE, and `done` pulses the next cycle.
  - Otherwise: enable=1, dir=1, go to UP.
- `stop` in SEEK/UP/DOWN/DWELL: enable=0 in the same cycle, go to IDLE, no `done` pulse. `stop` has priority over every other transition.
- `start` while busy is ignored, with no `err`.
- Comparisons are unsigned at full WIDTH. The sweep never wraps, because `lo < hi` is enforced.
- Config inputs are ignored after capture.

## Timing
- Reset values:
  - state IDLE, period count 0.
  - `enable`=0, `direction`=1.
  - `busy`=0, `done`=0, `err`=0.
- Reset asserted mid-sweep forces all outputs to reset values immediately (asynchronous).
- `start` sampled at edge k: `busy` and the first `enable` are high in cycle k+1.
- The counter visits lo..hi..lo. Each endpoint is seen for exactly one cycle per turnaround when DWELL is absent.
- One period from UP entry to the DOWN compare at `lo` spans `2*(hi-lo)` edges.
- `done` and `err` are registered, high for exactly one cycle. `busy` falls in the same cycle `done` rises.

## Configuration
- Macro: `SWEEP_CTRL_DWELL_EN`.
- Defined:
  - Adds input `dwell[7:0]`, captured on `start`.
  - At each `hi` and `lo` turnaround (not the final `lo`), the block enters DWELL with `enable`=0 for `dwell` cycles, then resumes in the opposite direction.
  - `dwell`=0 behaves identically to the macro being absent.
- Undefined: no `dwell` port, no DWELL state, immediate reversal.

## Structure
- Package `sweep_ctrl_pkg` holds:
  - the state enum typedef;
  - default `WIDTH`/`CYC_W` constants;
  - direction encodings `DIR_UP=1`, `DIR_DOWN=0`.
- Sub-module `dwell_timer`: loadable down-counter with a zero flag. Instantiated only under `SWEEP_CTRL_DWELL_EN`.

## Test plan
- Counter at 0, `start` with lo=2, hi=5, n_cycles=1 -> counter 0,1,2,3,4,5,4,3,2. Then `enable`=0, one `done` pulse, `busy` low.
- Counter at 9, lo=2, hi=5, n_cycles=2 -> seek down 9..2, then two full 2..5..2 periods, `done` once.
- `start` with lo=5, hi=5 or with n_cycles=0 -> `err` one-cycle pulse, `enable` stays 0, `busy` stays 0.
- `stop` while counter at 4 in UP -> `enable`=0 same cycle, counter holds 4, no `done`. A new `start` is then accepted.
- Reset asserted mid-DOWN -> outputs go to reset values without a clock edge. After release, the block stays IDLE until `start`.
- With `SWEEP_CTRL_DWELL_EN`, dwell=3, lo=0, hi=2, n=1 -> counter holds 2 for 4 cycles, then descends to 0, then `done`.

Source files
------------

// File: rtl/sweep_ctrl_pkg.sv
// Shared types and constants for the sweep sequencer.
// Optional feature macro: SWEEP_CTRL_DWELL_EN (adds the DWELL state).
package sweep_ctrl_pkg;

    localparam int unsigned SWEEP_WIDTH = 8;
    localparam int unsigned SWEEP_CYC_W = 8;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [2:0] {
        StIdle,
        StSeek,
        StUp,
`ifdef SWEEP_CTRL_DWELL_EN
        StDown,
        StDwell
`else
        StDown
`endif
    } sweep_state_e;

endpackage

// File: rtl/dwell_timer.sv
// Loadable 8-bit down-counter with a zero flag; holds the pause length at each
// sweep turnaround. Only instantiated when SWEEP_CTRL_DWELL_EN is defined.
module dwell_timer (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    output logic       o_zero
);

    logic [7:0] r_count;

    // Load on request, otherwise count down and park at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= 8'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != 8'd0) begin
            r_count <= r_count - 8'd1;
        end
    end

    assign o_zero = (r_count == 8'd0);

endmodule

// File: rtl/sweep_ctrl.sv
// Triangle-sweep sequencer for an external up/down counter: seeks to lo, then
// runs lo..hi..lo for n_cycles periods. enable/direction are combinational so
// turnarounds cost no idle cycle.
// Optional feature macro: SWEEP_CTRL_DWELL_EN (pause at each turnaround).
module sweep_ctrl
    import sweep_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = SWEEP_WIDTH,
    parameter int unsigned CYC_W = SWEEP_CYC_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [CYC_W-1:0] i_n_cycles,
    input  logic [WIDTH-1:0] i_counter_value,
`ifdef SWEEP_CTRL_DWELL_EN
    input  logic [7:0]       i_dwell,
`endif
    output logic             o_enable,
    output logic             o_direction,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    localparam logic [CYC_W-1:0] CYC_ONE = {{(CYC_W-1){1'b0}}, 1'b1};

    sweep_state_e     r_state;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic [CYC_W-1:0] r_n_cycles;
    logic [CYC_W-1:0] r_per_cnt;
    logic             r_done;
    logic             r_err;

    logic w_at_lo;
    logic w_above_lo;
    logic w_at_hi;
    logic w_last;
    logic w_cfg_ok;
    logic w_stop;
    logic w_has_dwell;

    assign w_at_lo    = (i_counter_value == r_lo);
    assign w_above_lo = (i_counter_value > r_lo);
    assign w_at_hi    = (i_counter_value == r_hi);
    assign w_last     = ((r_per_cnt + CYC_ONE) == r_n_cycles);
    assign w_cfg_ok   = (i_lo < i_hi) && (i_n_cycles != '0);
    assign w_stop     = i_stop && (r_state != StIdle);

`ifdef SWEEP_CTRL_DWELL_EN
    logic [7:0] r_dwell;
    logic       r_dwell_dir;
    logic       w_dwell_load;
    logic       w_dwell_zero;

    assign w_has_dwell  = (r_dwell != 8'd0);
    // Turnaround cycle itself is the first paused cycle, hence dwell-1.
    assign w_dwell_load = w_has_dwell && !w_stop &&
                          (((r_state == StUp) && w_at_hi) ||
                           ((r_state == StDown) && w_at_lo && !w_last));

    dwell_timer u_dwell_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_dwell_load),
        .i_load_val (r_dwell - 8'd1),
        .o_zero     (w_dwell_zero)
    );
`else
    assign w_has_dwell = 1'b0;
`endif

    // Counter drive decoded from state, live counter value and captured bounds.
    always_comb begin
        o_enable    = 1'b0;
        o_direction = DIR_UP;
        case (r_state)
            StSeek: begin
                o_enable    = 1'b1;
                o_direction = w_above_lo ? DIR_DOWN : DIR_UP;
            end
            StUp: begin
                o_enable = 1'b1;
                if (w_at_hi) begin
                    o_direction = DIR_DOWN;
                    o_enable    = !w_has_dwell;
                end
            end
            StDown: begin
                o_enable    = 1'b1;
                o_direction = DIR_DOWN;
                if (w_at_lo) begin
                    if (w_last) begin
                        o_enable = 1'b0;
                    end else begin
                        o_direction = DIR_UP;
                        o_enable    = !w_has_dwell;
                    end
                end
            end
`ifdef SWEEP_CTRL_DWELL_EN
            StDwell: begin
                o_enable    = w_dwell_zero;
                o_direction = r_dwell_dir;
            end
`endif
            default: ;
        endcase
        if (w_stop) begin
            o_enable = 1'b0;
        end
    end

    // Sequencer state, captured configuration and registered status pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_lo       <= '0;
            r_hi       <= '0;
            r_n_cycles <= '0;
            r_per_cnt  <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
`ifdef SWEEP_CTRL_DWELL_EN
            r_dwell     <= 8'd0;
            r_dwell_dir <= DIR_UP;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_stop) begin
                r_state <= StIdle;
            end else begin
                case (r_state)
                    StIdle: begin
                        if (i_start) begin
                            if (w_cfg_ok) begin
                                r_lo       <= i_lo;
                                r_hi       <= i_hi;
                                r_n_cycles <= i_n_cycles;
                                r_per_cnt  <= '0;
`ifdef SWEEP_CTRL_DWELL_EN
                                r_dwell    <= i_dwell;
`endif
                                r_state    <= StSeek;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    StSeek: begin
                        if (w_at_lo) begin
                            r_state <= StUp;
                        end
                    end
                    StUp: begin
                        if (w_at_hi) begin
`ifdef SWEEP_CTRL_DWELL_EN
                            if (w_has_dwell) begin
                                r_dwell_dir <= DIR_DOWN;
                                r_state     <= StDwell;
                            end else begin
                                r_state <= StDown;
                            end
`else
                            r_state <= StDown;
`endif
                        end
                    end
                    StDown: begin
                        if (w_at_lo) begin
                            r_per_cnt <= r_per_cnt + CYC_ONE;
                            if (w_last) begin
                                r_state <= StIdle;
                                r_done  <= 1'b1;
                            end else begin
`ifdef SWEEP_CTRL_DWELL_EN
                                if (w_has_dwell) begin
                                    r_dwell_dir <= DIR_UP;
                                    r_state     <= StDwell;
                                end else begin
                                    r_state <= StUp;
                                end
`else
                                r_state <= StUp;
`endif
                            end
                        end
                    end
`ifdef SWEEP_CTRL_DWELL_EN
                    StDwell: begin
                        if (w_dwell_zero) begin
                            r_state <= (r_dwell_dir == DIR_UP) ? StUp : StDown;
                        end
                    end
`endif
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign o_busy = (r_state != StIdle);
    assign o_done = r_done;
    assign o_err  = r_err;

endmodule
